// File: rtl/count_pwm_pkg.sv
// Shared types and default sizing for the count_pwm block and its count tracker.
package count_pwm_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_CYC_W = 8;

    typedef enum logic {
        S_SYNC = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/count_track.sv
// Follows the upstream mod-2**WIDTH count: remembers the previous value and
// classifies each new sample as hold, advance (possibly a wrap) or skip.
module count_track
    import count_pwm_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             wrap_now,
    output logic             skip
);

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    logic [WIDTH-1:0] prev_cnt;
    logic [WIDTH-1:0] prev_inc;
    logic             load;
    logic             hold;
    logic             advance;

    // While tracking, follow every sample; while resyncing, only latch the zero.
    assign load     = run || (cnt_in == CNT_ZERO);
    assign prev_inc = prev_cnt + WIDTH'(1);
    assign hold     = (cnt_in == prev_cnt);
    assign advance  = (cnt_in == prev_inc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_cnt <= '0;
        end else if (load) begin
            prev_cnt <= cnt_in;
        end
    end

    assign wrap_now = run && (prev_cnt == CNT_MAX) && (cnt_in == CNT_ZERO);
    assign skip     = run && !hold && !advance;

endmodule

// File: rtl/count_pwm.sv
// PWM generator driven by an external free-running count; duty is loaded via
// valid/ready and swapped in only at wrap. Define COUNT_PWM_INVERT_EN for an
// active-low, idle-high pwm_out.
module count_pwm
    import count_pwm_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CYC_W = DEF_CYC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH:0]   duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             wrap_pulse,
    output logic             err_skip,
    output logic [CYC_W-1:0] cycles
);

    localparam int unsigned DW = WIDTH + 1;
    localparam logic [DW-1:0] DUTY_MAX = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

`ifdef COUNT_PWM_INVERT_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif

    state_t           state;
    state_t           state_nxt;
    logic             pwm_nxt;
    logic             wrap_pulse_nxt;
    logic             err_skip_nxt;
    logic [CYC_W-1:0] cycles_nxt;
    logic [DW-1:0]    active_duty;
    logic [DW-1:0]    active_duty_nxt;
    logic [DW-1:0]    shadow;
    logic [DW-1:0]    shadow_nxt;
    logic             pending;
    logic             pending_nxt;

    logic             wrap_now;
    logic             skip;
    logic             accept;
    logic [DW-1:0]    eff_duty;
    logic             cmp;

    // Requests above a full period mean "always on".
    function automatic logic [DW-1:0] sat_duty(input logic [DW-1:0] d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

    count_track #(
        .WIDTH (WIDTH)
    ) u_track (
        .clk      (clk),
        .rst      (rst),
        .run      (state == S_RUN),
        .cnt_in   (cnt_in),
        .wrap_now (wrap_now),
        .skip     (skip)
    );

    assign duty_ready = !pending;
    assign accept     = duty_valid && !pending;

    // A pending duty takes effect on the very count that starts the new period.
    assign eff_duty = (wrap_now && pending) ? shadow : active_duty;
    assign cmp      = ({1'b0, cnt_in} < eff_duty);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_SYNC;
            pwm_out     <= POL;
            wrap_pulse  <= 1'b0;
            err_skip    <= 1'b0;
            cycles      <= '0;
            active_duty <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
        end else begin
            state       <= state_nxt;
            pwm_out     <= pwm_nxt;
            wrap_pulse  <= wrap_pulse_nxt;
            err_skip    <= err_skip_nxt;
            cycles      <= cycles_nxt;
            active_duty <= active_duty_nxt;
            shadow      <= shadow_nxt;
            pending     <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pwm_nxt         = pwm_out;
        wrap_pulse_nxt  = 1'b0;
        err_skip_nxt    = 1'b0;
        cycles_nxt      = cycles;
        active_duty_nxt = active_duty;
        shadow_nxt      = shadow;
        pending_nxt     = pending;

        case (state)
            S_SYNC: begin
                pwm_nxt = POL;
                if (cnt_in == CNT_ZERO) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (skip) begin
                    err_skip_nxt = 1'b1;
                    pwm_nxt      = POL;
                    state_nxt    = S_SYNC;
                end else begin
                    pwm_nxt        = cmp ^ POL;
                    wrap_pulse_nxt = wrap_now;
                    if (wrap_now) begin
                        cycles_nxt = cycles + CYC_W'(1);
                        if (pending) begin
                            active_duty_nxt = shadow;
                            pending_nxt     = 1'b0;
                        end
                    end
                end
            end
            default: begin
                pwm_nxt   = POL;
                state_nxt = S_SYNC;
            end
        endcase

        // Accept never coincides with a swap: it needs pending low.
        if (accept) begin
            shadow_nxt  = sat_duty(duty_in);
            pending_nxt = 1'b1;
        end
    end

endmodule

// File: doc/count_pwm.md
Name: count_pwm

Overview:
- Downstream consumer of the 4-bit free-running mod-16 counter value.
- Turns the counter's count stream into a PWM waveform. Duty is loaded through a valid/ready handshake and applied only at counter wrap (15->0), so pulses are glitch-free.
- Checks count continuity, pulses a wrap strobe, and counts completed PWM periods for status logic.

Parameters:
- WIDTH, 4, width of the incoming count; period is 2**WIDTH clocks.
- CYC_W, 8, width of the completed-period counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cnt_in  input  WIDTH  count value from the upstream counter, sampled every clk.
- duty_in  input  WIDTH+1  requested high-time in counts, 0..2**WIDTH.
- duty_valid  input  1  duty_in is valid.
- duty_ready  output  1  block can accept a new duty.
- pwm_out  output  1  registered PWM output.
- wrap_pulse  output  1  one-cycle strobe, registered, on each in-sequence wrap.
- err_skip  output  1  one-cycle strobe on a count discontinuity.
- cycles  output  CYC_W  completed PWM periods, modulo 2**CYC_W.

Behaviour:
- Reset (rst=0, async) drives:
  - state=SYNC, prev_cnt=0, active_duty=0, shadow=0, pending=0.
  - pwm_out=0, wrap_pulse=0, err_skip=0, cycles=0, duty_ready=1.
- States:
  - SYNC: pwm_out<=0. On a clk where cnt_in==0, load prev_cnt<=0 and go to RUN. Otherwise stay.
  - RUN, every clk: prev_cnt<=cnt_in, then classify cnt_in:
    - cnt_in==prev_cnt (hold): legal. pwm_out recomputed, no wrap.
    - cnt_in==prev_cnt+1 mod 2**WIDTH: legal advance.
      - wrap_now = (prev_cnt==2**WIDTH-1 && cnt_in==0).
    - anything else:
      - err_skip<=1 for one cycle, pwm_out<=0, state<=SYNC.
      - cycles, active_duty and shadow/pending unchanged.
- PWM:
  - eff_duty = (wrap_now && pending) ? shadow : active_duty.
  - pwm_out <= (cnt_in < eff_duty). Latency is one clk from cnt_in.
  - duty 0 gives constant low. Duty 2**WIDTH gives constant high. Compare is WIDTH+1 bits, unsigned.
- Wrap:
  - On wrap_now in RUN: wrap_pulse<=1 next cycle and cycles<=cycles+1 (wraps at 2**CYC_W).
  - If pending: active_duty<=shadow, pending<=0.
  - The transition SYNC->RUN is not a wrap: no pulse, no increment.
- Handshake:
  - duty_ready = !pending (combinational from the register).
  - Accept when duty_valid && duty_ready: shadow<=min(duty_in, 2**WIDTH), pending<=1.
  - duty_valid while not ready is ignored; the source must hold it.
  - Accept in the same cycle as a wrap with no prior pending: the new value applies at the following wrap, not the current one.
- The first period after SYNC exit has count 0 forced low, because SYNC holds output 0.
- Reset mid-period: all state cleared immediately. On release the block re-enters SYNC.

Optional Feature:
- COUNT_PWM_INVERT_EN defined:
  - pwm_out is active-low: pwm_out <= !(cnt_in < eff_duty).
  - SYNC, reset and err_skip conditions drive pwm_out=1 (idle high).
- Not defined: polarity as described above, idle low.
- No other behaviour changes.

Decomposition:
- Shared header count_pwm_defs.vh holds:
  - state encodings S_SYNC=1'b0, S_RUN=1'b1.
  - default WIDTH/CYC_W constants.
- One natural sub-module, count_track: prev_cnt register, hold/advance/skip classification, wrap_now. Output ports: wrap_now, skip.
- The top level holds the FSM, duty shadow/handshake, compare and cycle counter.

Test Plan:
- Reset, then free-running 0..15 count, duty 0: pwm_out=0 for all periods; wrap_pulse every 16 clks; cycles=1,2,3 after the 1st, 2nd and 3rd wraps.
- Load duty_in=5 mid-period (duty_ready drops to 0 after accept): pwm_out stays 0 until the wrap. In the next period it is high exactly for counts 0..4 (5 clks, delayed 1 clk). duty_ready returns to 1 after the wrap.
- duty_in=16, then duty_in=20: constant high; 20 saturates to 16, output identical.
- Count skip 6->9 in RUN: err_skip=1 for one clk, pwm_out=0, state SYNC. RUN resumes at the next cnt_in==0. cycles is not incremented by the resync.
- Counter held at 7 for 4 clks: no err_skip; pwm_out steady; wrap still detected when 15->0 occurs.
- rst asserted at count 10 with pending=1: all outputs 0 immediately, duty_ready=1, cycles=0. With COUNT_PWM_INVERT_EN, pwm_out=1 instead.
